// File: rtl/seq_check.sv
`default_nettype none
// ============================================================================
// Module   : seq_check
// Purpose  : Sequence monitor for the lab counter stage. Samples the 4-bit
//            count, 2-bit phase and terminal-count flag on every enabled
//            clock, locks after LOCK_N consecutive legal transitions, then
//            flags, counts and recovers from sequence breaks. Also counts
//            count wrap-arounds seen while locked.
// Ports    : clk        - rising-edge clock
//            reset      - asynchronous active-high reset, clears all state
//            en         - sample enable (inputs ignored when low)
//            clr        - synchronous clear of err_cnt, wrap_cnt, err_sticky
//            cnt_in     - upstream 4-bit count
//            phase_in   - upstream phase (advances once per count wrap)
//            carry_in   - upstream terminal-count flag
//            locked     - high while the monitor is in LOCK
//            mismatch   - one-clock pulse on a bad transition seen in LOCK
//            err_sticky - set by mismatch, cleared by clr/reset
//            err_cnt    - saturating count of mismatches
//            wrap_cnt   - modulo count of good 15->0 transitions in LOCK
//            state      - FSM state for debug
// Options  : SEQ_CHECK_PHASE_EN - when defined, phase_in is also checked
//            (it must advance exactly on a 15->0 count wrap and hold
//            otherwise). When undefined, phase_in is ignored.
// Revision : 1.0 - initial release
// ============================================================================
module seq_check #(
  parameter int LOCK_N = 3,   // good transitions needed to lock, 1..15
  parameter int CNT_W  = 8    // width of err_cnt and wrap_cnt
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic [3:0]       cnt_in,
  input  logic [1:0]       phase_in,
  input  logic             carry_in,
  output logic             locked,
  output logic             mismatch,
  output logic             err_sticky,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] wrap_cnt,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SYNC  = 2'b01,
    LOCK  = 2'b10,
    FAULT = 2'b11
  } state_t;

  localparam logic [3:0]       C_LOCK_N  = 4'(LOCK_N);
  localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [3:0]       r_prev_cnt;
  logic [3:0]       r_good_run;
  logic [3:0]       w_good_run_nxt;
  logic             w_good;
  logic             w_phase_ok;
  logic             w_bad_lock;   // bad transition evaluated while locked
  logic             w_wrap_lock;  // good 15->0 transition while locked
  logic             r_locked;
  logic             r_mismatch;
  logic             r_err_sticky;
  logic [CNT_W-1:0] r_err_cnt;
  logic [CNT_W-1:0] r_wrap_cnt;

  // --------------------------------------------------------------------------
  // Phase tracking (optional)
  // --------------------------------------------------------------------------
`ifdef SEQ_CHECK_PHASE_EN
  logic [1:0] r_prev_phase;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_prev_phase <= '0;
    end else if (en) begin
      r_prev_phase <= phase_in;
    end
  end

  // Phase advances only on the sample that follows a count of 15.
  assign w_phase_ok = (r_prev_cnt == 4'hF) ? (phase_in == r_prev_phase + 2'd1)
                                           : (phase_in == r_prev_phase);
`else
  logic w_unused_phase;

  assign w_unused_phase = ^phase_in;
  assign w_phase_ok     = 1'b1;
`endif

  // --------------------------------------------------------------------------
  // Transition check against the previous enabled sample
  // --------------------------------------------------------------------------
  assign w_good = (cnt_in == r_prev_cnt + 4'd1) &&
                  (carry_in == (cnt_in == 4'hF)) &&
                  w_phase_ok;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state, run length and event strobes
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt    = r_state;
    w_good_run_nxt = r_good_run;
    w_bad_lock     = 1'b0;
    w_wrap_lock    = 1'b0;

    case (r_state)
      IDLE: begin
        // First enabled sample only becomes the reference.
        if (en) begin
          w_state_nxt    = SYNC;
          w_good_run_nxt = '0;
        end
      end

      SYNC: begin
        if (en) begin
          if (w_good) begin
            w_good_run_nxt = r_good_run + 4'd1;
            if (w_good_run_nxt == C_LOCK_N) begin
              w_state_nxt = LOCK;
            end
          end else begin
            // Breaks while hunting for lock are silent: just restart the run.
            w_good_run_nxt = '0;
          end
        end
      end

      LOCK: begin
        if (en) begin
          if (w_good) begin
            w_wrap_lock = (r_prev_cnt == 4'hF);
          end else begin
            w_bad_lock  = 1'b1;
            w_state_nxt = FAULT;
          end
        end
      end

      FAULT: begin
        // FAULT is a fixed single-clock recovery step; it does not wait on
        // en. Any sample taken here is a fresh reference, not evaluated.
        w_state_nxt    = SYNC;
        w_good_run_nxt = '0;
      end

      default: begin
        w_state_nxt    = IDLE;
        w_good_run_nxt = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Reference sample and run-length registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_prev_cnt <= '0;
      r_good_run <= '0;
    end else begin
      if (en) begin
        r_prev_cnt <= cnt_in;
      end
      r_good_run <= w_good_run_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Status outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_locked     <= 1'b0;
      r_mismatch   <= 1'b0;
      r_err_sticky <= 1'b0;
    end else begin
      r_locked   <= (w_state_nxt == LOCK);
      r_mismatch <= w_bad_lock;
      // A new error wins over a simultaneous clear.
      if (w_bad_lock) begin
        r_err_sticky <= 1'b1;
      end else if (clr) begin
        r_err_sticky <= 1'b0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Event counters: clear first, then apply this edge's increment
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err_cnt <= '0;
    end else if (clr) begin
      r_err_cnt <= w_bad_lock ? C_CNT_ONE : '0;
    end else if (w_bad_lock && (r_err_cnt != C_CNT_MAX)) begin
      r_err_cnt <= r_err_cnt + C_CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wrap_cnt <= '0;
    end else if (clr) begin
      r_wrap_cnt <= w_wrap_lock ? C_CNT_ONE : '0;
    end else if (w_wrap_lock) begin
      r_wrap_cnt <= r_wrap_cnt + C_CNT_ONE;
    end
  end

  assign locked     = r_locked;
  assign mismatch   = r_mismatch;
  assign err_sticky = r_err_sticky;
  assign err_cnt    = r_err_cnt;
  assign wrap_cnt   = r_wrap_cnt;
  assign state      = r_state;

endmodule
`default_nettype wire
